// File: rtl/program_counter_if.sv
// rtl/program_counter_if.sv - request/status bundle between fetch control and the program counter
interface program_counter_if #(
    parameter int ADDR_WIDTH  = 8,
    parameter int STACK_DEPTH = 4
);
    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

    logic                  pcEn;
    logic                  branchEn;
    logic                  callEn;
    logic                  returnEn;
    logic [ADDR_WIDTH-1:0] branchTarget;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  delayEn;
    logic [DEPTH_W-1:0]    stackDepth;
    logic                  stackErr;

    modport master (
        output pcEn, branchEn, callEn, returnEn, branchTarget,
        input  pc, delayEn, stackDepth, stackErr
    );

    modport slave (
        input  pcEn, branchEn, callEn, returnEn, branchTarget,
        output pc, delayEn, stackDepth, stackErr
    );
endinterface

// File: rtl/program_counter.sv
// rtl/program_counter.sv - fetch-stage program counter with return-address stack
module program_counter #(
    parameter int                    ADDR_WIDTH  = 8,
    parameter int                    STACK_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR  = '0
) (
    input logic              clk,
    input logic              reset,
    program_counter_if.slave bus
);
    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
    localparam int PTR_W   = $clog2(STACK_DEPTH);
    localparam logic [DEPTH_W-1:0] FULL = DEPTH_W'(STACK_DEPTH);

    logic [ADDR_WIDTH-1:0] pcReg;
    logic [ADDR_WIDTH-1:0] pcNext;
    logic [ADDR_WIDTH-1:0] pcPlusOne;
    logic                  delayReg;
    logic                  delayNext;
    logic [DEPTH_W-1:0]    depthReg;
    logic [DEPTH_W-1:0]    depthNext;
    logic                  errReg;
    logic                  errNext;
    logic                  pushEn;
    logic [ADDR_WIDTH-1:0] stackMem [STACK_DEPTH];
    logic [PTR_W-1:0]      topIdx;
    logic [PTR_W-1:0]      pushIdx;

    // Stack grows upward: entry depth-1 is the top, entry depth is the next free slot.
    assign pcPlusOne = pcReg + ADDR_WIDTH'(1);
    assign topIdx    = PTR_W'(depthReg - DEPTH_W'(1));
    assign pushIdx   = PTR_W'(depthReg);

    // Pick the single action for this cycle: return > call > branch > increment.
    always_comb begin
        pcNext    = pcReg;
        delayNext = 1'b0;
        depthNext = depthReg;
        errNext   = errReg;
        pushEn    = 1'b0;
        if (bus.pcEn) begin
            if (bus.returnEn) begin
                if (depthReg != '0) begin
                    pcNext    = stackMem[topIdx];
                    depthNext = depthReg - DEPTH_W'(1);
                    delayNext = 1'b1;
                end else begin
                    // Underflow falls through as a plain increment with no redirect.
                    pcNext  = pcPlusOne;
                    errNext = 1'b1;
                end
            end else if (bus.callEn) begin
                pcNext    = bus.branchTarget;
                delayNext = 1'b1;
                if (depthReg != FULL) begin
                    pushEn    = 1'b1;
                    depthNext = depthReg + DEPTH_W'(1);
                end else begin
                    // Overflow still jumps; the return address is simply lost.
                    errNext = 1'b1;
                end
            end else if (bus.branchEn) begin
                pcNext    = bus.branchTarget;
                delayNext = 1'b1;
            end else begin
                pcNext = pcPlusOne;
            end
        end
    end

    // Architectural state registers; reset overrides the enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            pcReg    <= RESET_ADDR;
            delayReg <= 1'b0;
            depthReg <= '0;
            errReg   <= 1'b0;
        end else begin
            pcReg    <= pcNext;
            delayReg <= delayNext;
            depthReg <= depthNext;
            errReg   <= errNext;
        end
    end

    // Return-address storage; contents are meaningless above the current depth, so no reset.
    always_ff @(posedge clk) begin
        if (pushEn && !reset) begin
            stackMem[pushIdx] <= pcPlusOne;
        end
    end

    assign bus.pc         = pcReg;
    assign bus.delayEn    = delayReg;
    assign bus.stackDepth = depthReg;
    assign bus.stackErr   = errReg;
endmodule

// File: doc/program_counter.md
Name: program_counter

Overview:
- Fetch-stage program counter. Sits directly downstream of the delay counter and consumes its `pcEn` stall/enable output.
- Holds the current instruction address and advances by one each enabled cycle.
- Applies branch, call and return redirects, and keeps a small hardware return-address stack.
- On every taken redirect it drives a one-cycle `delayEn` pulse back to the delay counter, so fetch is held off while the pipeline refills.

Parameters:
ADDR_WIDTH, 8, width of `pc`, `branchTarget` and each stack entry
STACK_DEPTH, 4, number of return-address stack entries (power of two, ≥2)
RESET_ADDR, 0, value loaded into `pc` on reset

Ports:
clk  input  1  system clock; all state updates on its rising edge
reset  input  1  synchronous, active-high reset
pcEn  input  1  advance enable from delay counter; 0 = hold all state
branchEn  input  1  taken branch/jump request
callEn  input  1  subroutine call request (target on `branchTarget`)
returnEn  input  1  subroutine return request
branchTarget  input  ADDR_WIDTH  destination for branch or call
pc  output  ADDR_WIDTH  current fetch address (registered)
delayEn  output  1  one-cycle redirect pulse to delay counter (registered)
stackDepth  output  clog2(STACK_DEPTH+1)  number of valid stack entries
stackErr  output  1  sticky overflow/underflow flag

Behaviour:
- Reset (`reset`=1 at a rising edge; overrides everything, including `pcEn`):
  - `pc` = RESET_ADDR, `delayEn` = 0, `stackDepth` = 0, `stackErr` = 0.
  - Stack contents are don't-care.
  - Reset mid-operation discards any pending redirect and all stack entries.
- Hold: when `pcEn` = 0, `pc`, stack, `stackDepth` and `stackErr` keep their values.
  - `branchEn`, `callEn` and `returnEn` are ignored; upstream holds requests until `pcEn` = 1.
  - `delayEn` is driven 0 on every edge where `pcEn` = 0.
- Advance: when `pcEn` = 1, exactly one action occurs, in priority order return > call > branch > increment:
  - RETURN (`returnEn`=1, `stackDepth`>0): `pc` <= top entry; `stackDepth` decrements; `delayEn` <= 1.
  - RETURN underflow (`returnEn`=1, `stackDepth`=0): `pc` <= pc+1; `stackErr` <= 1; `delayEn` <= 0.
  - CALL (`callEn`=1, `stackDepth`<STACK_DEPTH): push pc+1 (modulo 2^ADDR_WIDTH); `stackDepth` increments; `pc` <= `branchTarget`; `delayEn` <= 1.
  - CALL overflow (`callEn`=1, `stackDepth`=STACK_DEPTH): `pc` <= `branchTarget`; push discarded and existing entries unchanged; `stackErr` <= 1; `delayEn` <= 1.
  - BRANCH (`branchEn`=1): `pc` <= `branchTarget`; `delayEn` <= 1. A branch to pc+1 is still a redirect and still pulses.
  - INCREMENT (no request): `pc` <= pc+1, wrapping from 2^ADDR_WIDTH−1 to 0; `delayEn` <= 0.
- Simultaneous requests: the lower-priority request is dropped, not queued. For example, `callEn`+`branchEn` performs only the call.
- `delayEn` timing and width:
  - High for exactly one cycle, in the cycle after the redirect edge.
  - Never high on two consecutive cycles, because the delay counter deasserts `pcEn` on the rising edge of `delayEn`.
  - This is safe because the delay counter is edge-triggered on `delayEn`.
- `stackErr` clears only on reset.
- Stack is LIFO; `stackDepth` is exact at all times.
- Latency: `pc` reflects an action one clock after the enabling edge. No combinational path exists from inputs to outputs.

Test Plan:
1. Reset then `pcEn`=1 for 5 cycles, no requests -> `pc` = 0,1,2,3,4,5; `delayEn` stays 0; `stackDepth`=0.
2. `pc`=0x10, `branchEn`=1 with target 0x40 for one enabled cycle -> `pc`=0x40 next cycle; `delayEn`=1 for exactly one cycle. Then set `pcEn`=0 for 7 cycles -> `pc` holds 0x40.
3. `pc`=0x05, CALL to 0x80; after 2 increments, RETURN -> `pc` goes 0x80, 0x81, 0x82, then 0x06. `stackDepth` goes 1 then 0. `delayEn` pulses once on the call and once on the return.
4. Five nested calls with STACK_DEPTH=4 -> `stackDepth` saturates at 4 and `stackErr`=1 after the 5th call. Then five returns -> the first four pop correctly in LIFO order; the 5th increments `pc` without pulsing `delayEn`.
5. `callEn`, `branchEn` and `returnEn` all high with `stackDepth`=1 -> return taken only; `pc` = popped address; `stackDepth`=0. Repeat with `pcEn`=0 -> no state change.
6. `pc`=0xFF, increment -> `pc`=0x00. Assert `reset` during a pending redirect with `stackDepth`=3 -> `pc`=RESET_ADDR, `delayEn`=0, `stackDepth`=0, `stackErr`=0 on the next cycle.
